dircc_rx_mailbox: RTL and testbench

Receive mailbox for the local DiRCC node. It terminates the router's local-delivery Avalon-ST stream (the "here" output port) and stores one complete packet at a time in an internal buffer. It exposes that packet to the node processor through a small Avalon-MM slave with status, control and data registers. While a packet is held and unreleased it applies backpressure, so the router stalls delivery to this node.

---
 rtl/dircc_pkg.sv | 32 +++
 rtl/dircc_rx_mailbox_ram.sv | 27 ++
 rtl/dircc_rx_mailbox.sv | 188 ++++++++++++++++++
 tb/tb_dircc_rx_mailbox.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dircc_pkg.sv
// Shared definitions for the DiRCC receive mailbox: state encoding,
// CSR word addresses and register bit positions.
package dircc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } dircc_rxmb_state_t;

    localparam logic [6:0] RXMB_STATUS    = 7'd0;
    localparam logic [6:0] RXMB_CONTROL   = 7'd1;
    localparam logic [6:0] RXMB_LENGTH    = 7'd2;
    localparam logic [6:0] RXMB_DATA_BASE = 7'd64;

    localparam int STAT_FULL      = 0;
    localparam int STAT_OVERFLOW  = 1;
    localparam int STAT_FRAMING   = 2;
    localparam int STAT_STRAY     = 3;
    localparam int STAT_COUNT_LSB = 16;

    localparam int CTRL_RELEASE = 0;
    localparam int CTRL_CLEAR   = 1;
    localparam int CTRL_IRQ_EN  = 2;

    // Byte length of a packet: four bytes per word minus the unused bytes of the last beat.
    function automatic logic [15:0] rxmb_byte_len(input logic [6:0] words, input logic [1:0] empty);
        return {7'd0, words, 2'b00} - {14'd0, empty};
    endfunction

endpackage

// File: rtl/dircc_rx_mailbox_ram.sv
// Packet buffer: one synchronous write port for the stream, one enabled
// synchronous read port for the CSR side (output holds between reads).
module dircc_rx_mailbox_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          i_wrEn,
    input  logic [AW-1:0] i_wrAddr,
    input  logic [31:0]   i_wrData,
    input  logic          i_rdEn,
    input  logic [AW-1:0] i_rdAddr,
    output logic [31:0]   o_rdData
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        if (i_rdEn) begin
            o_rdData <= r_mem[i_rdAddr];
        end
    end

endmodule

// File: rtl/dircc_rx_mailbox.sv
// Receive mailbox: captures one packet from the router's local-delivery stream,
// holds it with backpressure until the processor releases it over the CSR port.
module dircc_rx_mailbox
    import dircc_pkg::*;
#(
    parameter int MAX_WORDS = 32
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic [1:0]  in_empty,
    input  logic [6:0]  csr_address,
    input  logic        csr_read,
    output logic [31:0] csr_readdata,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic        irq
);

    localparam int         AW      = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [6:0] MAX_CNT = 7'(MAX_WORDS);

    dircc_rxmb_state_t r_state;
    logic [6:0]  r_count;
    logic [15:0] r_length;
    logic        r_overflow;
    logic        r_framing;
    logic        r_stray;
    logic        r_irqEn;
    logic        r_irq;
    logic [31:0] r_regData;
    logic        r_isData;

    logic        w_fire;
    logic        w_restart;
    logic [6:0]  w_wrIdx;
    logic [6:0]  w_nextWords;
    logic        w_overrun;
    logic        w_wrEn;
    logic        w_setStray;
    logic        w_setFraming;
    logic        w_setOverflow;
    logic        w_ctrlWr;
    logic        w_clear;
    logic        w_release;
    logic        w_dataHit;
    logic [31:0] w_status;
    logic [31:0] w_regValue;
    logic [31:0] w_ramData;
    logic        w_unused;

    assign in_ready = (r_state != HOLD);
    assign irq      = r_irq;

    assign w_fire        = in_valid && in_ready;
    assign w_restart     = (r_state == IDLE) || in_startofpacket;
    assign w_wrIdx       = w_restart ? 7'd0 : r_count;
    assign w_nextWords   = w_wrIdx + 7'd1;
    // A non-sop beat arriving once the buffer is full cannot be stored, eop or not.
    assign w_overrun     = (r_state == RECV) && !in_startofpacket && (r_count == MAX_CNT);
    assign w_wrEn        = w_fire && (((r_state == IDLE) && in_startofpacket) ||
                                      ((r_state == RECV) && !w_overrun));
    assign w_setStray    = w_fire && (r_state == IDLE) && !in_startofpacket;
    assign w_setFraming  = w_fire && (r_state == RECV) && in_startofpacket;
    assign w_setOverflow = w_fire && w_overrun;

    assign w_ctrlWr  = csr_write && (csr_address == RXMB_CONTROL);
    assign w_clear   = w_ctrlWr && csr_writedata[CTRL_CLEAR];
    assign w_release = w_ctrlWr && csr_writedata[CTRL_RELEASE];
    assign w_dataHit = csr_address[6] && ({1'b0, csr_address[5:0]} < MAX_CNT);
    assign w_unused  = ^csr_writedata[31:3];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state  <= IDLE;
            r_count  <= 7'd0;
            r_length <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire && in_startofpacket) begin
                        r_count <= w_nextWords;
                        if (in_endofpacket) begin
                            r_state  <= HOLD;
                            r_length <= rxmb_byte_len(w_nextWords, in_empty);
                        end else begin
                            r_state <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (w_fire) begin
                        if (w_overrun) begin
                            r_count <= 7'd0;
                            r_state <= in_endofpacket ? IDLE : DROP;
                        end else begin
                            r_count <= w_nextWords;
                            if (in_endofpacket) begin
                                r_state  <= HOLD;
                                r_length <= rxmb_byte_len(w_nextWords, in_empty);
                            end
                        end
                    end
                end
                HOLD: begin
                    if (w_release) begin
                        r_state <= IDLE;
                    end
                end
                DROP: begin
                    if (w_fire && in_endofpacket) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky error bits: a set event in the same cycle as a clear write wins.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_overflow <= 1'b0;
            r_framing  <= 1'b0;
            r_stray    <= 1'b0;
            r_irqEn    <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_overflow <= (r_overflow && !w_clear) || w_setOverflow;
            r_framing  <= (r_framing && !w_clear) || w_setFraming;
            r_stray    <= (r_stray && !w_clear) || w_setStray;
            if (w_ctrlWr) begin
                r_irqEn <= csr_writedata[CTRL_IRQ_EN];
            end
            r_irq <= (r_state == HOLD) && r_irqEn;
        end
    end

    always_comb begin
        w_status = '0;
        w_status[STAT_FULL]              = (r_state == HOLD);
        w_status[STAT_OVERFLOW]          = r_overflow;
        w_status[STAT_FRAMING]           = r_framing;
        w_status[STAT_STRAY]             = r_stray;
        w_status[STAT_COUNT_LSB +: 7]    = r_count;
    end

    always_comb begin
        w_regValue = '0;
        case (csr_address)
            RXMB_STATUS:  w_regValue = w_status;
            RXMB_CONTROL: w_regValue[CTRL_IRQ_EN] = r_irqEn;
            RXMB_LENGTH:  w_regValue = {16'd0, r_length};
            default:      w_regValue = '0;
        endcase
    end

    // Register values are snapshotted at the read so the result holds until the next read.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_regData <= 32'd0;
            r_isData  <= 1'b0;
        end else if (csr_read) begin
            r_regData <= w_regValue;
            r_isData  <= w_dataHit;
        end
    end

    assign csr_readdata = r_isData ? w_ramData : r_regData;

    dircc_rx_mailbox_ram #(
        .DEPTH (MAX_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk      (clk_clk),
        .i_wrEn   (w_wrEn),
        .i_wrAddr (w_wrIdx[AW-1:0]),
        .i_wrData (in_data),
        .i_rdEn   (csr_read && w_dataHit),
        .i_rdAddr (csr_address[AW-1:0]),
        .o_rdData (w_ramData)
    );

endmodule

// File: tb/tb_dircc_rx_mailbox.sv
// Directed bench for dircc_rx_mailbox: hand-computed packets, CSR reads and
// backpressure/irq timing, all compared through checkOutput.
module tb_dircc_rx_mailbox;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_startofpacket = 1'b0;
    logic        in_endofpacket = 1'b0;
    logic [1:0]  in_empty = '0;
    logic [6:0]  csr_address = '0;
    logic        csr_read = 1'b0;
    logic [31:0] csr_readdata;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic        irq;

    int total = 0;
    int bad = 0;

    always #5 clk_clk = ~clk_clk;

    dircc_rx_mailbox #(.MAX_WORDS(32)) dut (
        .clk_clk          (clk_clk),
        .reset_reset_n    (reset_reset_n),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .in_empty         (in_empty),
        .csr_address      (csr_address),
        .csr_read         (csr_read),
        .csr_readdata     (csr_readdata),
        .csr_write        (csr_write),
        .csr_writedata    (csr_writedata),
        .irq              (irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one beat from a falling edge; in_ready is stable until the next rising edge.
    task automatic applyStimulus(input logic [31:0] data, input logic sop, input logic eop,
                                 input logic [1:0] empty, output logic accepted);
        @(negedge clk_clk);
        in_data          = data;
        in_valid         = 1'b1;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_empty         = empty;
        accepted         = in_ready;
    endtask

    task automatic streamIdle();
        @(negedge clk_clk);
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_empty         = 2'd0;
    endtask

    task automatic sendPacket(input int n, input logic [31:0] mult, input logic [1:0] empty,
                              output int acc);
        logic a;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(mult * 32'(i + 1), (i == 0), (i == n - 1),
                          (i == n - 1) ? empty : 2'd0, a);
            if (a) acc++;
        end
        streamIdle();
    endtask

    task automatic csrRead(input logic [6:0] addr, output logic [31:0] data);
        @(negedge clk_clk);
        csr_address = addr;
        csr_read    = 1'b1;
        @(negedge clk_clk);
        csr_read = 1'b0;
        data     = csr_readdata;
    endtask

    task automatic csrWrite(input logic [6:0] addr, input logic [31:0] data);
        @(negedge clk_clk);
        csr_address   = addr;
        csr_writedata = data;
        csr_write     = 1'b1;
        @(negedge clk_clk);
        csr_write = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        a;
        int          acc;

        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        checkOutput("rst_rdata", csr_readdata, 32'd0);
        csrRead(7'd0, rd);  checkOutput("rst_status", rd, 32'd0);
        csrRead(7'd1, rd);  checkOutput("rst_control", rd, 32'd0);
        csrRead(7'd2, rd);  checkOutput("rst_length", rd, 32'd0);

        $display("[TB] 3-beat packet");
        sendPacket(3, 32'h11111111, 2'd2, acc);
        checkOutput("p3_acc", 32'(acc), 32'd3);
        checkOutput("p3_ready_low", 32'(in_ready), 32'd0);
        csrRead(7'd0, rd);  checkOutput("p3_status", rd, 32'h0003_0001);
        csrRead(7'd2, rd);  checkOutput("p3_length", rd, 32'd10);
        csrRead(7'd64, rd); checkOutput("p3_d0", rd, 32'h11111111);
        csrRead(7'd65, rd); checkOutput("p3_d1", rd, 32'h22222222);
        csrRead(7'd66, rd); checkOutput("p3_d2", rd, 32'h33333333);
        repeat (2) @(negedge clk_clk);
        checkOutput("p3_rdata_hold", csr_readdata, 32'h33333333);
        csrRead(7'd96, rd); checkOutput("beyond_buf", rd, 32'd0);
        csrRead(7'd3, rd);  checkOutput("unmapped", rd, 32'd0);
        // Release and a competing beat in the same cycle: the beat must not be taken.
        @(negedge clk_clk);
        csr_address = 7'd1; csr_writedata = 32'd1; csr_write = 1'b1;
        in_data = 32'h99999999; in_valid = 1'b1; in_startofpacket = 1'b1; in_endofpacket = 1'b1;
        checkOutput("rel_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk_clk);
        csr_write = 1'b0; in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
        checkOutput("rel_ready_high", 32'(in_ready), 32'd1);
        csrRead(7'd0, rd);  checkOutput("rel_status", rd & 32'hF, 32'd0);

        $display("[TB] single beat with irq");
        csrWrite(7'd1, 32'd4);
        csrRead(7'd1, rd);  checkOutput("irqen_rd", rd, 32'd4);
        sendPacket(1, 32'hCAFEF00D, 2'd0, acc);
        checkOutput("p1_ready_low", 32'(in_ready), 32'd0);
        checkOutput("p1_irq_t1", 32'(irq), 32'd0);
        @(negedge clk_clk);
        checkOutput("p1_irq_t2", 32'(irq), 32'd1);
        csrRead(7'd2, rd);  checkOutput("p1_length", rd, 32'd4);
        csrRead(7'd64, rd); checkOutput("p1_d0", rd, 32'hCAFEF00D);
        csrWrite(7'd1, 32'd5);
        checkOutput("p1_irq_lag", 32'(irq), 32'd1);
        checkOutput("p1_ready_rel", 32'(in_ready), 32'd1);
        @(negedge clk_clk);
        checkOutput("p1_irq_drop", 32'(irq), 32'd0);
        csrWrite(7'd1, 32'd0);

        $display("[TB] overflow packets");
        for (int n = 33; n <= 34; n++) begin
            sendPacket(n, 32'h00000101, 2'd0, acc);
            checkOutput($sformatf("ovf%0d_acc", n), 32'(acc), 32'(n));
            checkOutput($sformatf("ovf%0d_ready", n), 32'(in_ready), 32'd1);
            csrRead(7'd0, rd);
            checkOutput($sformatf("ovf%0d_status", n), rd & 32'hF, 32'd2);
        end
        sendPacket(2, 32'hA0A0A0A0, 2'd1, acc);
        csrRead(7'd0, rd);  checkOutput("ovf_next_status", rd, 32'h0002_0003);
        csrRead(7'd2, rd);  checkOutput("ovf_next_length", rd, 32'd7);
        csrRead(7'd64, rd); checkOutput("ovf_next_d0", rd, 32'hA0A0A0A0);
        csrRead(7'd65, rd); checkOutput("ovf_next_d1", rd, 32'h41414140);
        csrWrite(7'd1, 32'd1);
        csrWrite(7'd1, 32'd2);
        csrRead(7'd0, rd);  checkOutput("ovf_cleared", rd & 32'hF, 32'd0);

        $display("[TB] framing restart");
        applyStimulus(32'hDEADBEEF, 1'b1, 1'b0, 2'd0, a);
        sendPacket(2, 32'h0A0A0A0A, 2'd0, acc);
        csrRead(7'd0, rd);  checkOutput("frm_status", rd, 32'h0002_0005);
        csrRead(7'd2, rd);  checkOutput("frm_length", rd, 32'd8);
        csrRead(7'd64, rd); checkOutput("frm_d0", rd, 32'h0A0A0A0A);
        csrRead(7'd65, rd); checkOutput("frm_d1", rd, 32'h14141414);
        csrWrite(7'd1, 32'd3);

        $display("[TB] reset mid-packet");
        applyStimulus(32'h55555555, 1'b0, 1'b0, 2'd0, a);
        applyStimulus(32'h66666666, 1'b1, 1'b0, 2'd0, a);
        applyStimulus(32'h67676767, 1'b0, 1'b0, 2'd0, a);
        streamIdle();
        csrRead(7'd0, rd);  checkOutput("pre_rst_stray", rd & 32'hF, 32'd8);
        @(negedge clk_clk);
        reset_reset_n = 1'b0;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        csrRead(7'd0, rd);  checkOutput("post_rst_status", rd, 32'd0);
        sendPacket(2, 32'h01010101, 2'd0, acc);
        csrRead(7'd0, rd);  checkOutput("rst_next_status", rd, 32'h0002_0001);
        csrRead(7'd2, rd);  checkOutput("rst_next_length", rd, 32'd8);
        csrRead(7'd64, rd); checkOutput("rst_next_d0", rd, 32'h01010101);
        csrRead(7'd65, rd); checkOutput("rst_next_d1", rd, 32'h02020202);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
